// File: rtl/rgb2grey_pkg.sv
// Shared types and constants for the rgb2grey_axis luma filter.
// Pixel packing follows the stream: [23:16]=B, [15:8]=G, [7:0]=R.
package rgb2grey_pkg;

    localparam int PIX_W      = 24;
    localparam int COEF_R_DEF = 77;
    localparam int COEF_G_DEF = 150;
    localparam int COEF_B_DEF = 29;
    localparam int RND        = 128;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

    // Stage 1: weighted channels plus everything the later stages still need.
    typedef struct packed {
        logic [15:0] pr;
        logic [15:0] pg;
        logic [15:0] pb;
        rgb_t        pix;
        logic        user;
        logic        mode;
    } s1_t;

    typedef struct packed {
        logic [15:0] sum;
        rgb_t        pix;
        logic        user;
        logic        mode;
    } s2_t;

    typedef struct packed {
        rgb_t pix;
        logic user;
    } s3_t;

    // Rounded Q0.8 luma with the default weights; worst case 65408 fits 16 bits.
    function automatic logic [7:0] luma(rgb_t p);
        logic [15:0] s;
        s = 16'(p.r) * 16'(COEF_R_DEF)
          + 16'(p.g) * 16'(COEF_G_DEF)
          + 16'(p.b) * 16'(COEF_B_DEF)
          + 16'(RND);
        return s[15:8];
    endfunction

endpackage

// File: rtl/rgb2grey_stage.sv
// One valid/data pipeline register with its advance logic; the filter chains three.
// The stage accepts whenever it is empty or its current contents leave this cycle.
module rgb2grey_stage #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         up_valid_i,
    output logic         up_ready_o,
    input  logic [W-1:0] up_data_i,
    output logic         dn_valid_o,
    input  logic         dn_ready_i,
    output logic [W-1:0] dn_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        up_ready_o = !valid_q || dn_ready_i;
        valid_d    = valid_q;
        data_d     = data_q;
        if (up_ready_o) begin
            valid_d = up_valid_i;
            // Data only moves on a real beat, so idle input cycles leave it untouched.
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

endmodule

// File: rtl/rgb2grey_axis.sv
// AXI-stream RGB to grey filter: 3-stage luma pipeline, mode switched only at start of frame.
// Define RGB2GREY_STATS_EN to add the frame_cnt_o start-of-frame counter.
module rgb2grey_axis
    import rgb2grey_pkg::*;
#(
    parameter int BITS_PER_PIXEL = 24,
    parameter int COEF_R         = COEF_R_DEF,
    parameter int COEF_G         = COEF_G_DEF,
    parameter int COEF_B         = COEF_B_DEF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        mode_i,
`ifdef RGB2GREY_STATS_EN
    output logic [15:0] frame_cnt_o,
`endif
    input  logic        in_axis_tvalid,
    output logic        in_axis_tready,
    input  logic [23:0] in_axis_tdata,
    input  logic        in_axis_tuser,
    output logic        out_axis_tvalid,
    input  logic        out_axis_tready,
    output logic [23:0] out_axis_tdata,
    output logic        out_axis_tuser
);

    if (BITS_PER_PIXEL != PIX_W) begin : g_bpp_check
        $error("rgb2grey_axis: only BITS_PER_PIXEL=24 is supported");
    end
    if (COEF_R + COEF_G + COEF_B != 256) begin : g_coef_check
        $error("rgb2grey_axis: COEF_R+COEF_G+COEF_B must equal 256");
    end

    // Valid/ready: a beat transfers on a rising edge where valid and ready are both high;
    // a producer holds its beat stable until it transfers, and ready may depend on
    // downstream ready combinationally (the chain below ripples out_axis_tready back).

    rgb_t       in_pix;
    logic       beat_mode;
    logic       in_hs;
    logic       out_hs;
    logic       mode_q, mode_d;
    logic [7:0] luma_y;

    s1_t  s1_in, s1_q;
    s2_t  s2_in, s2_q;
    s3_t  s3_in, s3_q;
    logic v1, v2, v3;
    logic rdy1, rdy2, rdy3;

    assign in_pix = rgb_t'(in_axis_tdata);
    assign in_hs  = in_axis_tvalid && rdy1;
    assign out_hs = v3 && out_axis_tready;

    // A start-of-frame beat uses mode_i directly; the rest of the frame uses the latch.
    assign beat_mode = in_axis_tuser ? mode_i : mode_q;

    always_comb begin
        mode_d = mode_q;
        if (in_hs && in_axis_tuser) begin
            mode_d = mode_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        s1_in      = '0;
        s1_in.pr   = 16'(in_pix.r) * 16'(COEF_R);
        s1_in.pg   = 16'(in_pix.g) * 16'(COEF_G);
        s1_in.pb   = 16'(in_pix.b) * 16'(COEF_B);
        s1_in.pix  = in_pix;
        s1_in.user = in_axis_tuser;
        s1_in.mode = beat_mode;
    end

    always_comb begin
        s2_in      = '0;
        s2_in.sum  = s1_q.pr + s1_q.pg + s1_q.pb + 16'(RND);
        s2_in.pix  = s1_q.pix;
        s2_in.user = s1_q.user;
        s2_in.mode = s1_q.mode;
    end

    always_comb begin
        luma_y     = s2_q.sum[15:8];
        s3_in      = '0;
        s3_in.user = s2_q.user;
        if (s2_q.mode) begin
            s3_in.pix.b = luma_y;
            s3_in.pix.g = luma_y;
            s3_in.pix.r = luma_y;
        end else begin
            s3_in.pix = s2_q.pix;
        end
    end

    rgb2grey_stage #(.W($bits(s1_t))) u_s1 (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .up_valid_i (in_axis_tvalid),
        .up_ready_o (rdy1),
        .up_data_i  (s1_in),
        .dn_valid_o (v1),
        .dn_ready_i (rdy2),
        .dn_data_o  (s1_q)
    );

    rgb2grey_stage #(.W($bits(s2_t))) u_s2 (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .up_valid_i (v1),
        .up_ready_o (rdy2),
        .up_data_i  (s2_in),
        .dn_valid_o (v2),
        .dn_ready_i (rdy3),
        .dn_data_o  (s2_q)
    );

    rgb2grey_stage #(.W($bits(s3_t))) u_s3 (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .up_valid_i (v2),
        .up_ready_o (rdy3),
        .up_data_i  (s3_in),
        .dn_valid_o (v3),
        .dn_ready_i (out_axis_tready),
        .dn_data_o  (s3_q)
    );

    assign in_axis_tready  = rdy1;
    assign out_axis_tvalid = v3;
    assign out_axis_tdata  = s3_q.pix;
    assign out_axis_tuser  = s3_q.user;

`ifdef RGB2GREY_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Counts frames as they leave, wrapping naturally at 16 bits.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (out_hs && s3_q.user) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`else
    logic unused_out_hs;
    assign unused_out_hs = out_hs;
`endif

endmodule

// File: tb/tb_rgb2grey_axis.sv
// Self-checking bench for rgb2grey_axis: vector table, backpressure, random stalls, reset flush.
// Build with +define+RGB2GREY_STATS_EN to also check the frame counter.
module tb_rgb2grey_axis;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = '0;
    logic        in_user = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_data;
    logic        out_user;
`ifdef RGB2GREY_STATS_EN
    logic [15:0] frame_cnt;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [24:0] exp_q[$];
    int          occ = 0;
    logic        prev_stall = 1'b0;
    logic [24:0] prev_out = '0;
    logic        mode_m = 1'b0;
    bit          rand_rdy = 1'b0;

    typedef struct {
        logic        user;
        logic        mode;
        logic [23:0] din;
        logic [23:0] dout;
    } vec_t;

    vec_t vecs[12];

    rgb2grey_axis dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .mode_i          (mode),
`ifdef RGB2GREY_STATS_EN
        .frame_cnt_o     (frame_cnt),
`endif
        .in_axis_tvalid  (in_valid),
        .in_axis_tready  (in_ready),
        .in_axis_tdata   (in_data),
        .in_axis_tuser   (in_user),
        .out_axis_tvalid (out_valid),
        .out_axis_tready (out_ready),
        .out_axis_tdata  (out_data),
        .out_axis_tuser  (out_user)
    );

    // ---------------- clock / random downstream ready ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] model(input logic [23:0] d, input logic m);
        int         y;
        logic [7:0] yb;
        y  = (int'(d[7:0]) * 77 + int'(d[15:8]) * 150 + int'(d[23:16]) * 29 + 128) / 256;
        yb = 8'(y);
        return m ? {yb, yb, yb} : d;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        mode_m   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_data = 24'($urandom);
            in_user = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one beat, waits for acceptance, records its expected output.
    task automatic send(input logic [23:0] d, input logic u, input logic m,
                        input logic [23:0] exp_d, input bit use_model);
        int          t;
        logic        m_eff;
        logic [23:0] e;
        in_valid = 1'b1;
        in_data  = d;
        in_user  = u;
        mode     = m;
        t        = 0;
        @(negedge clk);
        while (!in_ready) begin
            if (t >= 1000) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", t);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            @(negedge clk);
            t++;
        end
        m_eff = u ? m : mode_m;
        if (u) mode_m = m;
        e = use_model ? model(d, m_eff) : exp_d;
        exp_q.push_back({u, e});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Counts edges from the accepting edge (inclusive) until out_valid is seen.
    task automatic check_latency(input logic [23:0] d, input logic u, input logic m,
                                 input logic [23:0] exp_d);
        int cnt;
        send(d, u, m, exp_d, 1'b0);
        in_valid = 1'b0;
        cnt = 1;
        @(negedge clk);
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check("latency", 32'(cnt), 32'd3);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            occ        = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'({out_user, out_data}), 32'(prev_out));
            end
            check("in_ready", 32'(in_ready), 32'((occ < 3) || out_ready));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat", {out_user, out_data});
                end else begin
                    check("out_beat", 32'({out_user, out_data}), 32'(exp_q.pop_front()));
                end
            end
            occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_user, out_data};
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        vecs[0]  = '{1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF};
        vecs[1]  = '{1'b0, 1'b1, 24'h000000, 24'h000000};
        vecs[2]  = '{1'b0, 1'b0, 24'h0000FF, 24'h4D4D4D};
        vecs[3]  = '{1'b0, 1'b1, 24'h00FF00, 24'h959595};
        vecs[4]  = '{1'b0, 1'b1, 24'hFF0000, 24'h1D1D1D};
        vecs[5]  = '{1'b0, 1'b1, 24'h808080, 24'h808080};
        vecs[6]  = '{1'b0, 1'b1, 24'h102030, 24'h232323};
        vecs[7]  = '{1'b1, 1'b0, 24'h123456, 24'h123456};
        vecs[8]  = '{1'b0, 1'b1, 24'h0000FF, 24'h0000FF};
        vecs[9]  = '{1'b0, 1'b1, 24'hABCDEF, 24'hABCDEF};
        vecs[10] = '{1'b1, 1'b1, 24'h0000FF, 24'h4D4D4D};
        vecs[11] = '{1'b0, 1'b0, 24'h00FF00, 24'h959595};

        do_reset();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_user", 32'(out_user), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef RGB2GREY_STATS_EN
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        check_latency(24'hFFFFFF, 1'b1, 1'b1, 24'hFFFFFF);
        drain();
        idle(2);

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].din, vecs[i].user, vecs[i].mode, vecs[i].dout, 1'b0);
        end
        idle(1);
        drain();

        // Stalled output with empty S1/S2 still takes two more beats, then blocks.
        out_ready = 1'b0;
        send(24'h0000FF, 1'b1, 1'b1, 24'h4D4D4D, 1'b0);
        idle(4);
        send(24'h00FF00, 1'b0, 1'b0, 24'h959595, 1'b0);
        send(24'hFF0000, 1'b0, 1'b1, 24'h1D1D1D, 1'b0);
        in_valid = 1'b1;
        in_data  = 24'h123456;
        @(negedge clk);
        check("full_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        idle(3);
        out_ready = 1'b1;
        drain();

        // Random backpressure and input gaps.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send(24'($urandom), (i % 40 == 0), 1'($urandom_range(0, 1)), 24'h0, 1'b1);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        // Reset with three beats in flight flushes the pipe at once.
        idle(2);
        out_ready = 1'b0;
        send(24'h111111, 1'b1, 1'b1, 24'h111111, 1'b0);
        send(24'h222222, 1'b0, 1'b1, 24'h222222, 1'b0);
        send(24'h333333, 1'b0, 1'b1, 24'h333333, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        mode_m = 1'b0;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_data", 32'(out_data), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        check_latency(24'h0000FF, 1'b0, 1'b1, 24'h0000FF);
        drain();
        idle(10);

`ifdef RGB2GREY_STATS_EN
        for (int f = 0; f < 3; f++) begin
            send(24'($urandom), 1'b1, 1'b1, 24'h0, 1'b1);
            send(24'($urandom), 1'b0, 1'b0, 24'h0, 1'b1);
        end
        in_valid = 1'b0;
        drain();
        idle(1);
        @(negedge clk);
        check("frame_cnt", 32'(frame_cnt), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
